// File: rtl/udlx_pkg.sv
// Shared definitions for the uDLX memory-access stage: FSM encoding,
// MEM/WB bubble constants and the default watchdog limit.
package udlx_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_t;

    // Bubble values are wide zero words sliced down to the configured widths.
    localparam logic [127:0] BUBBLE_INSTRUCTION = '0;
    localparam logic [127:0] BUBBLE_DATA        = '0;

    localparam int DEFAULT_TIMEOUT_CYCLES = 16;

endpackage

// File: rtl/memory_pipe.sv
// MEM/WB pipeline register. Loads a bubble on reset, stall, flush or
// watchdog abort; otherwise captures the completed stage results.
module memory_pipe
    import udlx_pkg::*;
#(
    parameter int DATA_WIDTH        = 32,
    parameter int REG_ADDR_WIDTH    = 5,
    parameter int INSTRUCTION_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         stall,
    input  logic                         flush,
    input  logic                         abort,
    input  logic                         read_done,
    input  logic [DATA_WIDTH-1:0]        rdata,
    input  logic [DATA_WIDTH-1:0]        alu_data,
    input  logic                         reg_wr_en,
    input  logic [REG_ADDR_WIDTH-1:0]    reg_wr_addr,
    input  logic                         write_back_mux_sel,
    input  logic [INSTRUCTION_WIDTH-1:0] instruction,
    output logic [DATA_WIDTH-1:0]        read_data_out,
    output logic [DATA_WIDTH-1:0]        alu_data_out,
    output logic                         reg_wr_en_out,
    output logic [REG_ADDR_WIDTH-1:0]    reg_wr_addr_out,
    output logic                         write_back_mux_sel_out,
    output logic [INSTRUCTION_WIDTH-1:0] instruction_out
);

    logic bubble;

    // A stalled edge must not re-present the previous instruction to write-back.
    assign bubble = stall | flush | abort;

    // MEM/WB register: bubble or capture of this cycle's results.
    always_ff @(posedge clk) begin
        if (rst || bubble) begin
            read_data_out          <= BUBBLE_DATA[DATA_WIDTH-1:0];
            alu_data_out           <= BUBBLE_DATA[DATA_WIDTH-1:0];
            reg_wr_en_out          <= 1'b0;
            reg_wr_addr_out        <= '0;
            write_back_mux_sel_out <= 1'b0;
            instruction_out        <= BUBBLE_INSTRUCTION[INSTRUCTION_WIDTH-1:0];
        end else begin
            read_data_out          <= read_done ? rdata : BUBBLE_DATA[DATA_WIDTH-1:0];
            alu_data_out           <= alu_data;
            reg_wr_en_out          <= reg_wr_en;
            reg_wr_addr_out        <= reg_wr_addr;
            write_back_mux_sel_out <= write_back_mux_sel;
            instruction_out        <= instruction;
        end
    end

endmodule

// File: rtl/memory_access.sv
// uDLX memory-access stage: req/ack handshake FSM towards a variable-latency
// data memory, upstream stall generation and the MEM/WB register.
// Optional watchdog enabled by defining UDLX_MEM_TIMEOUT_EN.
//
// state   | meaning
// ST_IDLE | no access outstanding; a new access issues combinationally
// ST_WAIT | access issued, holding req until ack (or watchdog abort)
module memory_access
    import udlx_pkg::*;
#(
    parameter int DATA_WIDTH        = 32,
    parameter int REG_ADDR_WIDTH    = 5,
    parameter int INSTRUCTION_WIDTH = 32,
    parameter int TIMEOUT_CYCLES    = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush_in,
    input  logic                         mem_data_rd_en_in,
    input  logic                         mem_data_wr_en_in,
    input  logic [DATA_WIDTH-1:0]        alu_data_in,
    input  logic [DATA_WIDTH-1:0]        mem_data_in,
    input  logic                         reg_wr_en_in,
    input  logic [REG_ADDR_WIDTH-1:0]    reg_wr_addr_in,
    input  logic                         write_back_mux_sel_in,
    input  logic [INSTRUCTION_WIDTH-1:0] instruction_in,
    output logic                         data_mem_req_out,
    output logic                         data_mem_we_out,
    output logic [DATA_WIDTH-1:0]        data_mem_addr_out,
    output logic [DATA_WIDTH-1:0]        data_mem_wdata_out,
    input  logic                         data_mem_ack_in,
    input  logic [DATA_WIDTH-1:0]        data_mem_rdata_in,
    output logic                         stall_out,
    output logic [DATA_WIDTH-1:0]        read_data_out,
    output logic [DATA_WIDTH-1:0]        alu_data_out,
    output logic                         reg_wr_en_out,
    output logic [REG_ADDR_WIDTH-1:0]    reg_wr_addr_out,
    output logic                         write_back_mux_sel_out,
    output logic [INSTRUCTION_WIDTH-1:0] instruction_out,
    output logic                         mem_error_out
);

    mem_state_t state, state_next;
    logic       access;
    logic       req;
    logic       abort;
    logic       read_done;
    logic       timeout_hit;

    assign access = mem_data_rd_en_in | mem_data_wr_en_in;

    // Port fields come straight from EX/MEM; upstream stall keeps them stable.
    assign data_mem_we_out    = mem_data_wr_en_in;
    assign data_mem_addr_out  = alu_data_in;
    assign data_mem_wdata_out = mem_data_in;
    assign data_mem_req_out   = req;

    assign stall_out = req & ~data_mem_ack_in;
    // Both enables set is treated as a store, so it never returns read data.
    assign read_done = req & data_mem_ack_in & mem_data_rd_en_in & ~mem_data_wr_en_in;

`ifdef UDLX_MEM_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] wait_count;
    logic            mem_error;

    assign timeout_hit   = (state == ST_WAIT) && (wait_count == TO_W'(TIMEOUT_CYCLES));
    assign mem_error_out = mem_error;

    // Watchdog: counts cycles of an outstanding request that saw no ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_count <= '0;
        end else if (state == ST_IDLE) begin
            wait_count <= stall_out ? TO_W'(1) : '0;
        end else if (stall_out) begin
            wait_count <= wait_count + TO_W'(1);
        end
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_error <= 1'b0;
        end else if (abort) begin
            mem_error <= 1'b1;
        end
    end
`else
    logic unused_timeout;

    assign timeout_hit    = 1'b0;
    assign mem_error_out  = 1'b0;
    assign unused_timeout = (TIMEOUT_CYCLES > 1);
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state and request/abort decode.
    always_comb begin
        state_next = state;
        req        = 1'b0;
        abort      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (access) begin
                    req = 1'b1;
                    if (!data_mem_ack_in) begin
                        state_next = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (timeout_hit) begin
                    abort      = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    req = 1'b1;
                    if (data_mem_ack_in) begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    memory_pipe #(
        .DATA_WIDTH        (DATA_WIDTH),
        .REG_ADDR_WIDTH    (REG_ADDR_WIDTH),
        .INSTRUCTION_WIDTH (INSTRUCTION_WIDTH)
    ) u_pipe (
        .clk                    (clk),
        .rst                    (rst),
        .stall                  (stall_out),
        .flush                  (flush_in),
        .abort                  (abort),
        .read_done              (read_done),
        .rdata                  (data_mem_rdata_in),
        .alu_data               (alu_data_in),
        .reg_wr_en              (reg_wr_en_in),
        .reg_wr_addr            (reg_wr_addr_in),
        .write_back_mux_sel     (write_back_mux_sel_in),
        .instruction            (instruction_in),
        .read_data_out          (read_data_out),
        .alu_data_out           (alu_data_out),
        .reg_wr_en_out          (reg_wr_en_out),
        .reg_wr_addr_out        (reg_wr_addr_out),
        .write_back_mux_sel_out (write_back_mux_sel_out),
        .instruction_out        (instruction_out)
    );

endmodule

// File: tb/tb_memory_access.sv
// Testbench for memory_access: directed scenarios plus randomized
// back-to-back traffic against a transaction-level reference model.
// The watchdog scenario runs only when UDLX_MEM_TIMEOUT_EN is defined.
module tb_memory_access;

    localparam int DW  = 32;
    localparam int RW  = 5;
    localparam int IW  = 32;
    localparam int TO  = 4;
    localparam int WBW = DW + DW + 1 + RW + 1 + IW;

    typedef struct {
        logic          rd;
        logic          wr;
        logic [DW-1:0] alu;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        logic          rwe;
        logic [RW-1:0] raddr;
        logic          sel;
        logic [IW-1:0] instr;
    } instr_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush_in;
    logic          mem_data_rd_en_in, mem_data_wr_en_in;
    logic [DW-1:0] alu_data_in, mem_data_in;
    logic          reg_wr_en_in;
    logic [RW-1:0] reg_wr_addr_in;
    logic          write_back_mux_sel_in;
    logic [IW-1:0] instruction_in;
    logic          data_mem_req_out, data_mem_we_out;
    logic [DW-1:0] data_mem_addr_out, data_mem_wdata_out;
    logic          data_mem_ack_in;
    logic [DW-1:0] data_mem_rdata_in;
    logic          stall_out;
    logic [DW-1:0] read_data_out, alu_data_out;
    logic          reg_wr_en_out;
    logic [RW-1:0] reg_wr_addr_out;
    logic          write_back_mux_sel_out;
    logic [IW-1:0] instruction_out;
    logic          mem_error_out;

    int vectors    = 0;
    int miscompares = 0;

    logic [WBW-1:0] obs_wb;
    assign obs_wb = {read_data_out, alu_data_out, reg_wr_en_out, reg_wr_addr_out,
                     write_back_mux_sel_out, instruction_out};

    always #5 clk = ~clk;

    memory_access #(
        .DATA_WIDTH        (DW),
        .REG_ADDR_WIDTH    (RW),
        .INSTRUCTION_WIDTH (IW),
        .TIMEOUT_CYCLES    (TO)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .flush_in               (flush_in),
        .mem_data_rd_en_in      (mem_data_rd_en_in),
        .mem_data_wr_en_in      (mem_data_wr_en_in),
        .alu_data_in            (alu_data_in),
        .mem_data_in            (mem_data_in),
        .reg_wr_en_in           (reg_wr_en_in),
        .reg_wr_addr_in         (reg_wr_addr_in),
        .write_back_mux_sel_in  (write_back_mux_sel_in),
        .instruction_in         (instruction_in),
        .data_mem_req_out       (data_mem_req_out),
        .data_mem_we_out        (data_mem_we_out),
        .data_mem_addr_out      (data_mem_addr_out),
        .data_mem_wdata_out     (data_mem_wdata_out),
        .data_mem_ack_in        (data_mem_ack_in),
        .data_mem_rdata_in      (data_mem_rdata_in),
        .stall_out              (stall_out),
        .read_data_out          (read_data_out),
        .alu_data_out           (alu_data_out),
        .reg_wr_en_out          (reg_wr_en_out),
        .reg_wr_addr_out        (reg_wr_addr_out),
        .write_back_mux_sel_out (write_back_mux_sel_out),
        .instruction_out        (instruction_out),
        .mem_error_out          (mem_error_out)
    );

    // Reference: what write-back should see once an instruction leaves the stage.
    function automatic logic [WBW-1:0] ref_wb(input instr_t t, input logic fl);
        logic [DW-1:0] rd_val;
        if (fl) return '0;
        rd_val = (t.rd && !t.wr) ? t.rdata : '0;
        return {rd_val, t.alu, t.rwe, t.raddr, t.sel, t.instr};
    endfunction

    function automatic instr_t rand_instr();
        instr_t t;
        int kind;
        kind    = $urandom_range(0, 3);
        t.rd    = (kind == 1) || (kind == 3);
        t.wr    = (kind == 2) || (kind == 3);
        t.alu   = $urandom;
        t.wdata = $urandom;
        t.rdata = $urandom;
        t.rwe   = $urandom_range(0, 1) == 1;
        t.raddr = RW'($urandom_range(0, 31));
        t.sel   = $urandom_range(0, 1) == 1;
        t.instr = $urandom;
        return t;
    endfunction

    function automatic instr_t idle_instr();
        instr_t t;
        t = rand_instr();
        t.rd = 1'b0;
        t.wr = 1'b0;
        return t;
    endfunction

    task automatic apply(input instr_t t, input logic fl, input logic ack);
        mem_data_rd_en_in     = t.rd;
        mem_data_wr_en_in     = t.wr;
        alu_data_in           = t.alu;
        mem_data_in           = t.wdata;
        reg_wr_en_in          = t.rwe;
        reg_wr_addr_in        = t.raddr;
        write_back_mux_sel_in = t.sel;
        instruction_in        = t.instr;
        data_mem_rdata_in     = t.rdata;
        data_mem_ack_in       = ack;
        flush_in              = fl;
    endtask

    task automatic test_reset();
        instr_t t;
        t = idle_instr();
        rst = 1'b1;
        apply(t, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({data_mem_req_out, stall_out, mem_error_out} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_ctrl got %b exp 000", {data_mem_req_out, stall_out, mem_error_out});
        end
        vectors++;
        if (obs_wb !== '0) begin
            miscompares++;
            $display("FAIL reset_wb got %h exp 0", obs_wb);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_zero_wait_load();
        instr_t t;
        t = rand_instr();
        t.rd = 1'b1; t.wr = 1'b0; t.alu = 32'h100; t.rdata = 32'hDEADBEEF; t.rwe = 1'b1;
        @(negedge clk);
        apply(t, 1'b0, 1'b1);
        #1;
        vectors++;
        if ({data_mem_req_out, data_mem_we_out, stall_out, data_mem_addr_out} !== {3'b100, 32'h100}) begin
            miscompares++;
            $display("FAIL zw_load_port got req=%b we=%b stall=%b addr=%h exp 1 0 0 00000100",
                     data_mem_req_out, data_mem_we_out, stall_out, data_mem_addr_out);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (read_data_out !== 32'hDEADBEEF || reg_wr_en_out !== 1'b1 || obs_wb !== ref_wb(t, 1'b0)) begin
            miscompares++;
            $display("FAIL zw_load_wb got %h exp %h", obs_wb, ref_wb(t, 1'b0));
        end
    endtask

    task automatic test_store_wait();
        instr_t t;
        t = rand_instr();
        t.rd = 1'b0; t.wr = 1'b1; t.alu = 32'h40; t.wdata = 32'h12345678;
        for (int c = 0; c <= 3; c++) begin
            @(negedge clk);
            apply(t, 1'b0, c == 3);
            #1;
            vectors++;
            if ({data_mem_req_out, data_mem_we_out, stall_out, data_mem_addr_out, data_mem_wdata_out}
                !== {1'b1, 1'b1, c < 3, 32'h40, 32'h12345678}) begin
                miscompares++;
                $display("FAIL store_port c=%0d got req=%b we=%b stall=%b addr=%h wdata=%h", c,
                         data_mem_req_out, data_mem_we_out, stall_out, data_mem_addr_out, data_mem_wdata_out);
            end
            @(posedge clk);
            #1;
            vectors++;
            if (obs_wb !== ((c < 3) ? '0 : ref_wb(t, 1'b0))) begin
                miscompares++;
                $display("FAIL store_wb c=%0d got %h exp %h", c, obs_wb, (c < 3) ? '0 : ref_wb(t, 1'b0));
            end
        end
    endtask

    task automatic test_both_enables();
        instr_t t;
        t = rand_instr();
        t.rd = 1'b1; t.wr = 1'b1;
        @(negedge clk);
        apply(t, 1'b0, 1'b1);
        #1;
        vectors++;
        if ({data_mem_req_out, data_mem_we_out, stall_out} !== 3'b110) begin
            miscompares++;
            $display("FAIL both_port got req=%b we=%b stall=%b exp 1 1 0",
                     data_mem_req_out, data_mem_we_out, stall_out);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (read_data_out !== '0 || obs_wb !== ref_wb(t, 1'b0)) begin
            miscompares++;
            $display("FAIL both_wb got %h exp %h", obs_wb, ref_wb(t, 1'b0));
        end
    endtask

    task automatic test_flush();
        instr_t t;
        t = rand_instr();
        t.rd = 1'b1; t.wr = 1'b0; t.rwe = 1'b1; t.instr = 32'hA5A5_0001;
        @(negedge clk);
        apply(t, 1'b1, 1'b1);
        #1;
        vectors++;
        if ({data_mem_req_out, stall_out} !== 2'b10) begin
            miscompares++;
            $display("FAIL flush_port got req=%b stall=%b exp 1 0", data_mem_req_out, stall_out);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (reg_wr_en_out !== 1'b0 || instruction_out !== '0 || obs_wb !== '0) begin
            miscompares++;
            $display("FAIL flush_wb got %h exp 0", obs_wb);
        end
    endtask

    task automatic test_reset_mid_access();
        instr_t t;
        instr_t z;
        t = rand_instr();
        t.rd = 1'b1; t.wr = 1'b0; t.rwe = 1'b1;
        for (int c = 0; c <= 2; c++) begin
            @(negedge clk);
            apply(t, 1'b0, 1'b0);
            rst = (c == 2);
            @(posedge clk);
        end
        #1;
        vectors++;
        if (obs_wb !== '0 || mem_error_out !== 1'b0) begin
            miscompares++;
            $display("FAIL rstmid_wb got %h err=%b exp 0 0", obs_wb, mem_error_out);
        end
        z = idle_instr();
        @(negedge clk);
        rst = 1'b0;
        apply(z, 1'b0, 1'b0);
        #1;
        vectors++;
        if ({data_mem_req_out, stall_out} !== 2'b00) begin
            miscompares++;
            $display("FAIL rstmid_idle got req=%b stall=%b exp 0 0", data_mem_req_out, stall_out);
        end
        @(posedge clk);
        t = rand_instr();
        t.rd = 1'b1; t.wr = 1'b0;
        for (int c = 0; c <= 1; c++) begin
            @(negedge clk);
            apply(t, 1'b0, c == 1);
            #1;
            vectors++;
            if ({data_mem_req_out, stall_out} !== {1'b1, c == 0}) begin
                miscompares++;
                $display("FAIL rstmid_reload_port c=%0d got req=%b stall=%b", c, data_mem_req_out, stall_out);
            end
            @(posedge clk);
        end
        #1;
        vectors++;
        if (obs_wb !== ref_wb(t, 1'b0)) begin
            miscompares++;
            $display("FAIL rstmid_reload_wb got %h exp %h", obs_wb, ref_wb(t, 1'b0));
        end
    endtask

    task automatic test_back_to_back(input int n);
        instr_t t;
        int k, last;
        logic fl, acc;
        for (int i = 0; i < n; i++) begin
            t    = rand_instr();
            k    = $urandom_range(0, 3);
            fl   = ($urandom_range(0, 4) == 0);
            acc  = t.rd | t.wr;
            last = acc ? k : 0;
            for (int c = 0; c <= last; c++) begin
                @(negedge clk);
                apply(t, (c == last) ? fl : ($urandom_range(0, 1) == 1), acc && (c == last));
                #1;
                vectors++;
                if ({data_mem_req_out, data_mem_we_out, stall_out, data_mem_addr_out, data_mem_wdata_out}
                    !== {acc, t.wr, acc && (c < last), t.alu, t.wdata}) begin
                    miscompares++;
                    $display("FAIL b2b_port i=%0d c=%0d got req=%b we=%b stall=%b exp %b %b %b", i, c,
                             data_mem_req_out, data_mem_we_out, stall_out, acc, t.wr, acc && (c < last));
                end
                @(posedge clk);
                #1;
                vectors++;
                if (obs_wb !== ((c < last) ? '0 : ref_wb(t, fl))) begin
                    miscompares++;
                    $display("FAIL b2b_wb i=%0d c=%0d got %h exp %h", i, c, obs_wb,
                             (c < last) ? '0 : ref_wb(t, fl));
                end
            end
        end
        vectors++;
        if (mem_error_out !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_error got %b exp 0", mem_error_out);
        end
    endtask

`ifdef UDLX_MEM_TIMEOUT_EN
    task automatic test_timeout();
        instr_t t;
        instr_t z;
        t = rand_instr();
        t.rd = 1'b1; t.wr = 1'b0; t.rwe = 1'b1;
        for (int c = 0; c <= TO; c++) begin
            @(negedge clk);
            apply(t, 1'b0, c == TO);
            #1;
            vectors++;
            if ({data_mem_req_out, stall_out} !== {c < TO, c < TO}) begin
                miscompares++;
                $display("FAIL timeout_port c=%0d got req=%b stall=%b", c, data_mem_req_out, stall_out);
            end
            @(posedge clk);
            #1;
            vectors++;
            if (obs_wb !== '0) begin
                miscompares++;
                $display("FAIL timeout_wb c=%0d got %h exp 0", c, obs_wb);
            end
        end
        z = idle_instr();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            apply(z, 1'b0, 1'b0);
            @(posedge clk);
            #1;
            vectors++;
            if (mem_error_out !== 1'b1) begin
                miscompares++;
                $display("FAIL timeout_sticky c=%0d got %b exp 1", c, mem_error_out);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (mem_error_out !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_clear got %b exp 0", mem_error_out);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_zero_wait_load();
        test_store_wait();
        test_both_enables();
        test_flush();
        test_reset_mid_access();
        test_back_to_back(60);
`ifdef UDLX_MEM_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
